program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 13 +
 rtl/byte_word_assembler.sv | 31 +++
 rtl/program_loader.sv | 90 +++++++++
 tb/tb_program_loader.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: state encoding and stream-format constants shared by the program loader.
package loader_pkg;
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LEN_HI = 3'd1;
   localparam logic [2:0] LEN_LO = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] CHECK  = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
   localparam logic [2:0] ERROR  = 3'd6;
   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int CHECKSUM_WIDTH = 8;
endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: shifts stream bytes MSB-first into a 32-bit word and flags the 4th byte.
module byte_word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_complete_o
);
   logic [31:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;
   always_comb begin
      shift_d = clear_i ? 32'd0 : shift_i ? {shift_q[23:0], byte_i} : shift_q;
      cnt_d   = clear_i ? 2'd0 : shift_i ? cnt_q + 2'd1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end
   // Combinational: the word is in shift_q on the cycle after this pulse.
   assign word_complete_o = shift_i && cnt_q == 2'(BYTES_PER_WORD - 1);
   assign word_o          = shift_q;
endmodule

// File: rtl/program_loader.sv
// program_loader: parses a length-prefixed, checksummed byte stream into program memory writes
// and holds the processor in reset until a verified image has been loaded.
module program_loader
   import loader_pkg::*;
#(
   parameter int          MEMORY_DEPTH = 32,
   parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        mem_write_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_data_o,
   output logic        cpu_reset_o,
   output logic        done_o,
   output logic        error_o
);
   logic [2:0]                state_q, state_d;
   logic [15:0]               count_q, count_d;
   logic [15:0]               index_q, index_d;
   logic [CHECKSUM_WIDTH-1:0] sum_q, sum_d;
   logic                      mem_write_q, mem_write_d;
   logic                      xfer, restart, word_complete;
   logic [15:0]               len_n;
   logic [31:0]               word;
   assign byte_ready_o = state_q == LEN_HI || state_q == LEN_LO || state_q == DATA || state_q == CHECK;
   assign xfer         = byte_valid_i && byte_ready_o;
   assign restart      = start_i && (state_q == IDLE || state_q == DONE || state_q == ERROR);
   assign len_n        = {count_q[15:8], byte_data_i};
   byte_word_assembler u_asm (
      .clk             (clk),
      .reset           (reset),
      .clear_i         (restart),
      .shift_i         (xfer && state_q == DATA),
      .byte_i          (byte_data_i),
      .word_o          (word),
      .word_complete_o (word_complete)
   );
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      index_d     = mem_write_q ? index_q + 16'd1 : index_q;
      sum_d       = sum_q;
      mem_write_d = word_complete;
      if (restart) begin
         state_d = LEN_HI;
         index_d = '0;
         sum_d   = '0;
      end else if (xfer) begin
         if (state_q == LEN_HI) begin
            count_d = {byte_data_i, 8'd0};
            state_d = LEN_LO;
         end else if (state_q == LEN_LO) begin
            count_d = len_n;
            state_d = 32'(len_n) > MEMORY_DEPTH ? ERROR : len_n == 16'd0 ? CHECK : DATA;
         end else if (state_q == DATA) begin
            sum_d   = sum_q + byte_data_i;
            // index_q still names the word being completed; it advances during the write cycle.
            state_d = word_complete && index_q == count_q - 16'd1 ? CHECK : DATA;
         end else if (state_q == CHECK) begin
            state_d = byte_data_i == sum_q ? DONE : ERROR;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         index_q     <= '0;
         sum_q       <= '0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         index_q     <= index_d;
         sum_q       <= sum_d;
         mem_write_q <= mem_write_d;
      end
   end
   assign mem_write_o   = mem_write_q;
   assign mem_data_o    = word;
   assign mem_address_o = BASE_ADDRESS + {14'd0, index_q, 2'b00};
   assign cpu_reset_o   = state_q != DONE;
   assign done_o        = state_q == DONE;
   assign error_o       = state_q == ERROR;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed streams; expected memory writes are queued by the stimulus and
// checked by an independent write monitor, status outputs are checked after each stream.
module tb_program_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_i = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_data_i = 8'd0;
   logic        byte_ready_o, mem_write_o, cpu_reset_o, done_o, error_o;
   logic [31:0] mem_address_o, mem_data_o;
   logic [63:0] exp_q[$];
   logic [63:0] e;
   int          tests = 0;
   int          fails = 0;
   always #5 clk = ~clk;
   program_loader dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .byte_valid_i  (byte_valid_i),
      .byte_data_i   (byte_data_i),
      .byte_ready_o  (byte_ready_o),
      .mem_write_o   (mem_write_o),
      .mem_address_o (mem_address_o),
      .mem_data_o    (mem_data_o),
      .cpu_reset_o   (cpu_reset_o),
      .done_o        (done_o),
      .error_o       (error_o)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (mem_write_o) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got %h @%h expected none", mem_data_o, mem_address_o);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", mem_address_o, e[63:32]);
            chk("write_data", mem_data_o, e[31:0]);
         end
      end
   end
   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask
   task automatic send(input logic [7:0] b, input int stall);
      int t = 0;
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      while (!byte_ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("ready_timeout", 32'(byte_ready_o), 32'd1);
      @(negedge clk);
      byte_valid_i = 1'b0;
      repeat (stall) @(negedge clk);
   endtask
   task automatic send_nominal(input logic [7:0] cks, input int stall);
      logic [7:0] s [11] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'h00};
      s[10] = cks;
      exp_q.push_back({32'h0040_0000, 32'h2008_0005});
      exp_q.push_back({32'h0040_0004, 32'h8C09_0004});
      for (int i = 0; i < 11; i++) send(s[i], stall);
   endtask
   task automatic status(input string name, input logic d, input logic er, input logic cr);
      @(negedge clk);
      chk({name, "_done"}, 32'(done_o), 32'(d));
      chk({name, "_error"}, 32'(error_o), 32'(er));
      chk({name, "_cpu_reset"}, 32'(cpu_reset_o), 32'(cr));
      chk({name, "_ready"}, 32'(byte_ready_o), 32'd0);
      chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
   endtask
   task automatic check_reset_values(input string name);
      chk({name, "_ready"}, 32'(byte_ready_o), 32'd0);
      chk({name, "_write"}, 32'(mem_write_o), 32'd0);
      chk({name, "_addr"}, mem_address_o, 32'h0040_0000);
      chk({name, "_data"}, mem_data_o, 32'd0);
      chk({name, "_cpu_reset"}, 32'(cpu_reset_o), 32'd1);
      chk({name, "_done"}, 32'(done_o), 32'd0);
      chk({name, "_error"}, 32'(error_o), 32'd0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_values("reset");
      pulse_start();
      chk("len_hi_ready", 32'(byte_ready_o), 32'd1);
      send_nominal(8'hC6, 0);
      status("nominal", 1'b1, 1'b0, 1'b0);
      pulse_start();
      chk("restart_cpu_reset", 32'(cpu_reset_o), 32'd1);
      chk("restart_done", 32'(done_o), 32'd0);
      send_nominal(8'hC7, 0);
      status("bad_cks", 1'b0, 1'b1, 1'b1);
      pulse_start();
      send(8'h00, 0);
      send(8'h21, 0);
      status("overflow", 1'b0, 1'b1, 1'b1);
      pulse_start();
      send(8'h00, 0);
      send(8'h00, 0);
      send(8'h00, 0);
      status("zero_len", 1'b1, 1'b0, 1'b0);
      pulse_start();
      send(8'h00, 0);
      send(8'h00, 0);
      send(8'h01, 0);
      status("zero_len_bad", 1'b0, 1'b1, 1'b1);
      pulse_start();
      send_nominal(8'hC6, 3);
      status("stalls", 1'b1, 1'b0, 1'b0);
      pulse_start();
      exp_q.push_back({32'h0040_0000, 32'h2008_0005});
      send(8'h00, 0);
      send(8'h02, 0);
      send(8'h20, 0);
      send(8'h08, 0);
      send(8'h00, 0);
      send(8'h05, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_values("mid_reset");
      chk("mid_reset_writes_left", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      pulse_start();
      send_nominal(8'hC6, 1);
      status("after_reset", 1'b1, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
